// File: rtl/bpu_pkg.sv
// Shared encodings for the branch predict unit: branch types, PC-select codes
// and the reset/saturation values of the 2-bit history counters.
package bpu_pkg;

    typedef enum logic [1:0] {
        J_NONE   = 2'b00,
        J_RSVD   = 2'b01,
        J_JUMP   = 2'b10,
        J_BRANCH = 2'b11
    } j_e;

    typedef enum logic [1:0] {
        PC_SEQ     = 2'b00,
        PC_BR      = 2'b01,
        PC_JMP     = 2'b10,
        PC_RECOVER = 2'b11
    } pc_src_e;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] STRONG_T  = 2'b11;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline-facing bundle of the branch predict unit: IF lookup, EX resolution
// and the performance counters. The predictor is the slave side.
interface branch_predict_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;

    logic              ex_valid;
    logic [1:0]        ex_j;
    logic              ex_cond;
    logic [ADDR_W-1:0] ex_pc;
    logic [ADDR_W-1:0] ex_target;
    logic              ex_pred_taken;
    logic [ADDR_W-1:0] ex_pred_target;
    logic              flush;
    logic [1:0]        pc_src;

    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  mispred_cnt;

    modport master (
        output if_valid, if_pc,
        output ex_valid, ex_j, ex_cond, ex_pc, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, flush, pc_src, branch_cnt, mispred_cnt
    );

    modport slave (
        input  if_valid, if_pc,
        input  ex_valid, ex_j, ex_cond, ex_pc, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, flush, pc_src, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/sat_counter2.sv
// One BHT entry: 2-bit saturating up/down counter, resets to weak-not-taken.
// set_i (jump install) wins over inc_i/dec_i.
module sat_counter2
    import bpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       set_i,
    output logic [1:0] cnt_o
);
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (set_i) begin
            cnt_d = STRONG_T;
        end else if (inc_i && (cnt_q != STRONG_T)) begin
            cnt_d = cnt_q + 2'b01;
        end else if (dec_i && (cnt_q != STRONG_NT)) begin
            cnt_d = cnt_q - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= WEAK_NT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_predict_unit.sv
// IF-stage branch predictor (direct-mapped BHT + tagged BTB) with EX-stage
// misprediction resolution and saturating branch/mispredict counters.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_unit_if.slave bpu
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] ex_tag;
    logic             unused_pc_lsbs;

    assign if_idx = bpu.if_pc[IDX_W+1:2];
    assign if_tag = bpu.if_pc[ADDR_W-1:IDX_W+2];
    assign ex_idx = bpu.ex_pc[IDX_W+1:2];
    assign ex_tag = bpu.ex_pc[ADDR_W-1:IDX_W+2];
    // Instructions are word aligned, so the byte offset never selects anything.
    assign unused_pc_lsbs = ^{bpu.if_pc[1:0], bpu.ex_pc[1:0]};

    j_e ex_j_e;
    assign ex_j_e = j_e'(bpu.ex_j);

    // Update strobes; an asserted rst swallows whatever EX presents this cycle.
    logic upd_en;
    logic bht_upd;
    logic jmp_upd;
    logic btb_we;

    assign upd_en  = bpu.ex_valid && !rst;
    assign bht_upd = upd_en && (ex_j_e == J_BRANCH);
    assign jmp_upd = upd_en && (ex_j_e == J_JUMP);
    assign btb_we  = jmp_upd || (bht_upd && bpu.ex_cond);

    logic [DEPTH-1:0] ex_sel;
    logic [1:0]       bht_cnt [DEPTH];

    assign ex_sel = DEPTH'(1) << ex_idx;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bht
            sat_counter2 u_bht (
                .clk   (clk),
                .rst   (rst),
                .inc_i (bht_upd && ex_sel[gi] && bpu.ex_cond),
                .dec_i (bht_upd && ex_sel[gi] && !bpu.ex_cond),
                .set_i (jmp_upd && ex_sel[gi]),
                .cnt_o (bht_cnt[gi])
            );
        end
    endgenerate

    logic [DEPTH-1:0]  btb_valid_q;
    logic [DEPTH-1:0]  btb_valid_d;
    logic [TAG_W-1:0]  btb_tag_q    [DEPTH];
    logic [ADDR_W-1:0] btb_target_q [DEPTH];

    always_comb begin
        btb_valid_d = btb_valid_q;
        if (btb_we) begin
            btb_valid_d[ex_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid_q <= '0;
        end else begin
            btb_valid_q <= btb_valid_d;
        end
    end

    // Tag/target need no reset: an entry is ignored until its valid bit is set.
    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag_q[ex_idx]    <= ex_tag;
            btb_target_q[ex_idx] <= bpu.ex_target;
        end
    end

    // Lookup reads the registered tables, so a same-index update in EX shows up
    // one cycle later.
    logic btb_hit;
    logic pred_taken;

    assign btb_hit         = btb_valid_q[if_idx] && (btb_tag_q[if_idx] == if_tag);
    assign pred_taken      = !rst && bpu.if_valid && btb_hit && bht_cnt[if_idx][1];
    assign bpu.pred_taken  = pred_taken;
    assign bpu.pred_target = pred_taken ? btb_target_q[if_idx] : '0;

    logic    tgt_match;
    logic    res_flush;
    pc_src_e res_pc_src;

    assign tgt_match = bpu.ex_pred_taken && (bpu.ex_pred_target == bpu.ex_target);

    always_comb begin
        res_flush  = 1'b0;
        res_pc_src = PC_SEQ;
        if (!rst && bpu.ex_valid) begin
            case (ex_j_e)
                J_BRANCH: begin
                    if (bpu.ex_cond) begin
                        if (!tgt_match) begin
                            res_flush  = 1'b1;
                            res_pc_src = PC_BR;
                        end
                    end else if (bpu.ex_pred_taken) begin
                        res_flush  = 1'b1;
                        res_pc_src = PC_RECOVER;
                    end
                end
                J_JUMP: begin
                    if (!tgt_match) begin
                        res_flush  = 1'b1;
                        res_pc_src = PC_JMP;
                    end
                end
                default: begin
                    res_flush  = 1'b0;
                    res_pc_src = PC_SEQ;
                end
            endcase
        end
    end

    assign bpu.flush  = res_flush;
    assign bpu.pc_src = res_pc_src;

    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (bht_upd && (branch_cnt_q != {CNT_W{1'b1}})) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (res_flush && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign bpu.branch_cnt  = branch_cnt_q;
    assign bpu.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: one vector per cycle, expected values
// queued by the stimulus and checked by an independent monitor on the falling edge.
module tb_branch_predict_unit;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    branch_predict_unit #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bpu (bus.slave)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        iv;
        logic [31:0] ipc;
        logic        ev;
        logic [1:0]  j;
        logic        c;
        logic [31:0] epc;
        logic [31:0] etgt;
        logic        ept;
        logic [31:0] eptg;
        logic        x_pt;
        logic [31:0] x_ptg;
        logic        x_fl;
        logic [1:0]  x_ps;
        logic        x_cc;
        int          x_bc;
        int          x_mc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(string nm, logic r, logic iv, logic [31:0] ipc,
                                logic ev, logic [1:0] j, logic c, logic [31:0] epc,
                                logic [31:0] etgt, logic ept, logic [31:0] eptg,
                                logic x_pt, logic [31:0] x_ptg, logic x_fl,
                                logic [1:0] x_ps, logic x_cc, int x_bc, int x_mc);
        vec_t v;
        v.name = nm;  v.rst = r;    v.iv = iv;     v.ipc = ipc;
        v.ev = ev;    v.j = j;      v.c = c;       v.epc = epc;
        v.etgt = etgt; v.ept = ept; v.eptg = eptg;
        v.x_pt = x_pt; v.x_ptg = x_ptg; v.x_fl = x_fl; v.x_ps = x_ps;
        v.x_cc = x_cc; v.x_bc = x_bc;   v.x_mc = x_mc;
        vecs.push_back(v);
    endfunction

    task automatic chk(string nm, string field, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, field, act, exp);
        end
    endtask

    // Monitor: compares whatever the stimulus queued for the current cycle.
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                $display("vec %-14s pt=%0b ptg=0x%0h flush=%0b pc_src=%0d bcnt=%0d mcnt=%0d",
                         e.name, bus.pred_taken, bus.pred_target, bus.flush, bus.pc_src,
                         bus.branch_cnt, bus.mispred_cnt);
                chk(e.name, "pred_taken",  32'(bus.pred_taken), 32'(e.x_pt));
                chk(e.name, "pred_target", bus.pred_target,     e.x_ptg);
                chk(e.name, "flush",       32'(bus.flush),      32'(e.x_fl));
                chk(e.name, "pc_src",      32'(bus.pc_src),     32'(e.x_ps));
                if (e.x_cc) begin
                    chk(e.name, "branch_cnt",  32'(bus.branch_cnt),  32'(e.x_bc));
                    chk(e.name, "mispred_cnt", 32'(bus.mispred_cnt), 32'(e.x_mc));
                end
            end
        end
    end

    initial begin
        bus.if_valid = 1'b0;       bus.if_pc = '0;
        bus.ex_valid = 1'b0;       bus.ex_j = 2'b00;   bus.ex_cond = 1'b0;
        bus.ex_pc = '0;            bus.ex_target = '0;
        bus.ex_pred_taken = 1'b0;  bus.ex_pred_target = '0;

        //   name           rst iv ipc       ev j     c  epc       etgt      ept eptg     | pt ptg      fl ps     cc bc mc
        add("rst0",         1, 1, 32'h40,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     0, 32'h0,   0, 2'b00, 0, 0, 0);
        add("rst1",         1, 1, 32'h40,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     0, 32'h0,   0, 2'b00, 0, 0, 0);
        add("post_rst",     0, 1, 32'h40,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     0, 32'h0,   0, 2'b00, 1, 0, 0);
        add("br_miss",      0, 1, 32'h40,   1, 2'b11, 1, 32'h40,   32'h100,  0, 32'h0,     0, 32'h0,   1, 2'b01, 1, 0, 0);
        add("br_learn",     0, 1, 32'h40,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     1, 32'h100, 0, 2'b00, 1, 1, 1);
        add("br_hit1",      0, 1, 32'h40,   1, 2'b11, 1, 32'h40,   32'h100,  1, 32'h100,   1, 32'h100, 0, 2'b00, 1, 1, 1);
        add("br_hit2",      0, 1, 32'h40,   1, 2'b11, 1, 32'h40,   32'h100,  1, 32'h100,   1, 32'h100, 0, 2'b00, 1, 2, 1);
        add("br_hit3",      0, 1, 32'h40,   1, 2'b11, 1, 32'h40,   32'h100,  1, 32'h100,   1, 32'h100, 0, 2'b00, 1, 3, 1);
        add("br_nt_pred",   0, 1, 32'h40,   1, 2'b11, 0, 32'h40,   32'h100,  1, 32'h100,   1, 32'h100, 1, 2'b11, 1, 4, 1);
        add("bht_wt",       0, 1, 32'h40,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     1, 32'h100, 0, 2'b00, 1, 5, 2);
        add("br_nt_pred2",  0, 1, 32'h40,   1, 2'b11, 0, 32'h40,   32'h100,  1, 32'h100,   1, 32'h100, 1, 2'b11, 1, 5, 2);
        add("bht_wnt",      0, 1, 32'h40,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     0, 32'h0,   0, 2'b00, 1, 6, 3);
        add("jmp_miss",     0, 1, 32'h80,   1, 2'b10, 0, 32'h80,   32'h200,  0, 32'h0,     0, 32'h0,   1, 2'b10, 1, 6, 3);
        add("jmp_learn",    0, 1, 32'h80,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     1, 32'h200, 0, 2'b00, 1, 6, 4);
        add("jmp_hit",      0, 1, 32'h80,   1, 2'b10, 0, 32'h80,   32'h200,  1, 32'h200,   1, 32'h200, 0, 2'b00, 1, 6, 4);
        add("jmp_badtgt",   0, 1, 32'h80,   1, 2'b10, 0, 32'h80,   32'h200,  1, 32'h204,   1, 32'h200, 1, 2'b10, 1, 6, 4);
        add("alias_inst",   0, 1, 32'h1040, 1, 2'b11, 1, 32'h40,   32'h100,  0, 32'h0,     0, 32'h0,   1, 2'b01, 1, 6, 5);
        add("alias_own",    0, 1, 32'h40,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     1, 32'h100, 0, 2'b00, 1, 7, 6);
        add("alias_exinv",  0, 1, 32'h1040, 0, 2'b11, 1, 32'h1040, 32'h300,  0, 32'h0,     0, 32'h0,   0, 2'b00, 1, 7, 6);
        add("rsvd_j",       0, 1, 32'h1040, 1, 2'b01, 1, 32'h1040, 32'h300,  0, 32'h0,     0, 32'h0,   0, 2'b00, 1, 7, 6);
        add("alias_repl",   0, 1, 32'h1040, 1, 2'b11, 1, 32'h1040, 32'h300,  0, 32'h0,     0, 32'h0,   1, 2'b01, 1, 7, 6);
        add("alias_new",    0, 1, 32'h1040, 0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     1, 32'h300, 0, 2'b00, 1, 7, 7);
        add("evicted",      0, 1, 32'h40,   1, 2'b11, 1, 32'h80,   32'h200,  1, 32'h204,   0, 32'h0,   1, 2'b01, 1, 7, 7);
        add("rst_mid",      1, 1, 32'h80,   1, 2'b11, 1, 32'h40,   32'h100,  0, 32'h0,     0, 32'h0,   0, 2'b00, 1, 7, 7);
        add("post_rst2",    0, 1, 32'h80,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     0, 32'h0,   0, 2'b00, 1, 0, 0);
        add("rst_btb40",    0, 1, 32'h40,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     0, 32'h0,   0, 2'b00, 1, 0, 0);
        add("rst_btb1040",  0, 1, 32'h1040, 0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     0, 32'h0,   0, 2'b00, 1, 0, 0);
        add("br_nt_np",     0, 1, 32'h40,   1, 2'b11, 0, 32'h40,   32'h100,  0, 32'h0,     0, 32'h0,   0, 2'b00, 1, 0, 0);
        add("final",        0, 1, 32'h40,   0, 2'b00, 0, 32'h0,    32'h0,    0, 32'h0,     0, 32'h0,   0, 2'b00, 1, 1, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst                = vecs[i].rst;
            bus.if_valid       = vecs[i].iv;
            bus.if_pc          = vecs[i].ipc;
            bus.ex_valid       = vecs[i].ev;
            bus.ex_j           = vecs[i].j;
            bus.ex_cond        = vecs[i].c;
            bus.ex_pc          = vecs[i].epc;
            bus.ex_target      = vecs[i].etgt;
            bus.ex_pred_taken  = vecs[i].ept;
            bus.ex_pred_target = vecs[i].eptg;
            sb.push_back(vecs[i]);
        end

        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
        bus.if_valid = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
